alu_muldiv: RTL and testbench

- Parametrised-width MIPS-style ALU for the lab datapath.
- Keeps the single-cycle logic/arithmetic ops and adds an iterative multiply/divide unit with architectural HI/LO registers.
- The unit uses a start/busy/done handshake.
- The controller stalls the pipeline on busy; the datapath reads HI/LO through the MFHI/MFLO op codes.

---
 rtl/alu_muldiv_if.sv | 27 ++
 rtl/alu_muldiv.sv | 216 +++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// alu_muldiv bus: operands, op select, start handshake,
// combinational result and mul/div status plus HI/LO.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alucont;
  logic             start;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;
  logic             divzero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output a, b, alucont, start,
    input  result, zero, busy, done, divzero, hi, lo
  );

  modport slave (
    input  a, b, alucont, start,
    output result, zero, busy, done, divzero, hi, lo
  );
endinterface

// File: rtl/alu_muldiv.sv
// MIPS-style ALU with iterative radix-2 multiply/divide
// and architectural HI/LO registers.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input logic         clk,
  input logic         reset_n,
  alu_muldiv_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [1:0]         op_q, op_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               divz_q, divz_d;

  logic [WIDTH-1:0]   res;

  // single-cycle result mux, independent of mul/div state
  always_comb begin
    res = '0;
    unique case (bus.alucont)
      4'b0000: res = bus.a & bus.b;
      4'b0001: res = bus.a | bus.b;
      4'b0010: res = bus.a + bus.b;
      4'b0011: res = bus.a ^ bus.b;
      4'b0100: res = bus.a & ~bus.b;
      4'b0101: res = bus.a | ~bus.b;
      4'b0110: res = bus.a - bus.b;
      4'b0111: res = {{(WIDTH-1){1'b0}},
                      $signed(bus.a) < $signed(bus.b)};
      4'b1110: res = {{(WIDTH-1){1'b0}},
                      bus.a < bus.b};
      4'b1100: res = hi_q;
      4'b1101: res = lo_q;
      4'b1000, 4'b1001,
      4'b1010, 4'b1011,
      4'b1111: res = '0;
    endcase
  end

  logic             sgn_in;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             is_div, b_zero;

  // operand magnitudes for the accept cycle
  always_comb begin
    sgn_in = bus.alucont[0];
    is_div = bus.alucont[1];
    a_neg  = sgn_in & bus.a[WIDTH-1];
    b_neg  = sgn_in & bus.b[WIDTH-1];
    abs_a  = a_neg ? -bus.a : bus.a;
    abs_b  = b_neg ? -bus.b : bus.b;
    b_zero = (bus.b == '0);
  end

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] div_next;

  // one radix-2 step; acc holds {upper, lower} halves
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + {1'b0, (acc_q[0] ? dvs_q : '0)};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, dvs_q});
    div_sub  = div_sh[WIDTH-1:0] - dvs_q;
    rem_new  = div_ge ? div_sub : div_sh[WIDTH-1:0];
    div_next = {rem_new, acc_q[WIDTH-2:0], div_ge};
  end

  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0]   quo, rem, quo_f, rem_f;

  // sign correction applied when leaving RUN
  always_comb begin
    quo    = acc_q[WIDTH-1:0];
    rem    = acc_q[2*WIDTH-1:WIDTH];
    prod_f = (op_q[0] & (sa_q ^ sb_q)) ? -acc_q : acc_q;
    quo_f  = (op_q[0] & (sa_q ^ sb_q)) ? -quo : quo;
    rem_f  = (op_q[0] & sa_q) ? -rem : rem;
  end

  // mul/div sequencer next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    divz_d  = divz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && bus.alucont[3:2] == 2'b10) begin
          state_d = RUN;
          busy_d  = 1'b1;
          cnt_d   = '0;
          op_d    = bus.alucont[1:0];
          sa_d    = a_neg;
          sb_d    = b_neg;
          divz_d  = 1'b0;
          dz_d    = is_div & b_zero;
          dvs_d   = is_div ? abs_b : abs_a;
          if (is_div & b_zero)
            acc_d = {{WIDTH{1'b0}}, bus.a};
          else if (is_div)
            acc_d = {{WIDTH{1'b0}}, abs_a};
          else
            acc_d = {{WIDTH{1'b0}}, abs_b};
        end
      end
      RUN: begin
        if (dz_q) begin
          // divide by zero: skip iteration, raw a to HI
          state_d = FIN;
          done_d  = 1'b1;
          divz_d  = 1'b1;
          hi_d    = acc_q[WIDTH-1:0];
          lo_d    = '1;
        end else if (cnt_q == LAST) begin
          state_d = FIN;
          done_d  = 1'b1;
          if (op_q[1]) begin
            hi_d = rem_f;
            lo_d = quo_f;
          end else begin
            {hi_d, lo_d} = prod_f;
          end
        end else begin
          acc_d = op_q[1] ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // sequencer state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
    end
  end

  assign bus.result  = res;
  assign bus.zero    = (res == '0);
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.divzero = divz_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: arithmetic reference model with a
// per-cycle compare process plus directed literal checks.
module tb_alu_muldiv;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  alu_muldiv_if #(.WIDTH(W)) bus ();

  alu_muldiv #(.WIDTH(W), .CW(6)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference model: timeline of an op plus its arithmetic result
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          m_dz, p_dz, m_done, m_act;
  int          m_cnt, m_lat;

  task automatic calc(input logic [1:0] op,
                      input logic [31:0] x,
                      input logic [31:0] y);
    longint s, q, r;
    logic [63:0] u;
    p_dz = 1'b0;
    case (op)
      2'd0: begin
        u = {32'b0, x} * {32'b0, y};
        {p_hi, p_lo} = u;
      end
      2'd1: begin
        s = longint'($signed(x)) * longint'($signed(y));
        {p_hi, p_lo} = s;
      end
      2'd2: begin
        if (y == 0) begin
          p_dz = 1'b1; p_hi = x; p_lo = '1;
        end else begin
          p_lo = x / y; p_hi = x % y;
        end
      end
      default: begin
        if (y == 0) begin
          p_dz = 1'b1; p_hi = x; p_lo = '1;
        end else begin
          q = longint'($signed(x)) / longint'($signed(y));
          r = longint'($signed(x)) % longint'($signed(y));
          p_lo = q[31:0]; p_hi = r[31:0];
        end
      end
    endcase
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi = 0; m_lo = 0; m_dz = 0;
      m_done = 0; m_act = 0; m_cnt = 0;
    end else if (m_act) begin
      m_cnt++;
      m_done = 0;
      if (m_cnt == m_lat) begin
        m_hi = p_hi; m_lo = p_lo;
        m_dz = p_dz; m_done = 1;
      end else if (m_cnt == m_lat + 1) begin
        m_act = 0;
      end
    end else if (bus.start && bus.alucont[3:2] == 2'b10) begin
      calc(bus.alucont[1:0], bus.a, bus.b);
      m_act = 1;
      m_cnt = 0;
      m_lat = p_dz ? 1 : W + 1;
      m_dz = 0;
    end
  end

  function automatic logic [31:0] exp_res();
    logic [31:0] x, y;
    x = bus.a;
    y = bus.b;
    case (bus.alucont)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return x + y;
      4'd3:  return x ^ y;
      4'd4:  return x & ~y;
      4'd5:  return x | ~y;
      4'd6:  return x - y;
      4'd7:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd14: return (x < y) ? 32'd1 : 32'd0;
      4'd12: return m_hi;
      4'd13: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  // per-cycle compare against the model
  always @(posedge clk) begin
    logic [31:0] er;
    #2;
    er = exp_res();
    chk("result", bus.result, er);
    chk("zero", bus.zero, er == 0);
    chk("busy", bus.busy, m_act);
    chk("done", bus.done, m_done);
    chk("hi", bus.hi, m_hi);
    chk("lo", bus.lo, m_lo);
    chk("divzero", bus.divzero, m_dz);
  end

  logic acc_dz;

  task automatic run_op(input string nm,
                        input logic [3:0] op,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input int exp_lat);
    int lat;
    lat = -1;
    repeat (2) @(negedge clk);
    bus.a = x; bus.b = y;
    bus.alucont = op; bus.start = 1'b1;
    @(posedge clk);
    #3 acc_dz = bus.divzero;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(posedge clk);
      #3;
      if (bus.done) lat = i;
    end
    chk({nm, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    int nd;
    logic [31:0] sh, sl;
    bus.a = '0; bus.b = '0;
    bus.alucont = '0; bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_divzero", bus.divzero, 0);
    reset_n = 1'b1;

    @(negedge clk);
    bus.a = 32'hFFFF_FFFF; bus.b = 32'd1; bus.alucont = 4'b0010;
    #1 chk("add_wrap", bus.result, 0);
    chk("add_zero", bus.zero, 1);
    @(negedge clk); bus.alucont = 4'b0111;
    #1 chk("slt", bus.result, 1);
    @(negedge clk); bus.alucont = 4'b1110;
    #1 chk("sltu", bus.result, 0);
    @(negedge clk);
    bus.a = 32'hA5A5_A5A5; bus.b = 32'hA5A5_A5A5; bus.alucont = 4'b0011;
    #1 chk("xor", bus.result, 0);
    chk("xor_zero", bus.zero, 1);

    run_op("mult", 4'b1001, 32'hFFFF_FFFE, 32'd3, 33);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFA);
    @(negedge clk); bus.alucont = 4'b1101;
    #1 chk("mflo", bus.result, 32'hFFFF_FFFA);

    run_op("multu", 4'b1000, 32'hFFFF_FFFE, 32'd3, 33);
    chk("multu_hi", bus.hi, 32'h2);
    chk("multu_lo", bus.lo, 32'hFFFF_FFFA);

    run_op("div", 4'b1011, 32'hFFFF_FFF9, 32'd2, 33);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);

    run_op("divu", 4'b1010, 32'd7, 32'd2, 33);
    chk("divu_lo", bus.lo, 3);
    chk("divu_hi", bus.hi, 1);
    chk("divu_dz", bus.divzero, 0);

    run_op("divmin", 4'b1011, 32'h8000_0000, 32'hFFFF_FFFF, 33);
    chk("divmin_lo", bus.lo, 32'h8000_0000);
    chk("divmin_hi", bus.hi, 0);
    chk("divmin_dz", bus.divzero, 0);

    run_op("divz", 4'b1010, 32'h1234, 32'd0, 1);
    chk("divz_hi", bus.hi, 32'h1234);
    chk("divz_lo", bus.lo, 32'hFFFF_FFFF);
    chk("divz_flag", bus.divzero, 1);

    run_op("mul56", 4'b1000, 32'd5, 32'd6, 33);
    chk("dz_clear_on_start", acc_dz, 0);
    chk("mul56_lo", bus.lo, 30);

    repeat (2) @(negedge clk);
    bus.a = 32'h1_0000; bus.b = 32'h10;
    bus.alucont = 4'b1000; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.alucont = 4'b1101;
    #1 chk("mflo_run", bus.result, 30);
    bus.a = 32'd100; bus.b = 32'hFFFF_FFFD;
    bus.alucont = 4'b1011; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; bus.alucont = 4'b0010;
    nd = 0; sh = '1; sl = '1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #3;
      if (bus.done) begin
        nd++; sh = bus.hi; sl = bus.lo;
      end
    end
    chk("ign_ndone", nd, 1);
    chk("ign_lo", sl, 32'h10_0000);
    chk("ign_hi", sh, 0);

    @(negedge clk);
    bus.a = 32'd5; bus.b = 32'd7;
    bus.alucont = 4'b1001; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1 chk("mrst_hi", bus.hi, 0);
    chk("mrst_lo", bus.lo, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_done", bus.done, 0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst_idle", bus.busy, 0);

    bus.a = 32'd3; bus.b = 32'd4;
    bus.alucont = 4'b0010; bus.start = 1'b1;
    repeat (3) @(negedge clk);
    chk("nonmd_busy", bus.busy, 0);
    chk("nonmd_res", bus.result, 7);
    bus.start = 1'b0;

    @(negedge clk);
    bus.a = 32'd7; bus.b = 32'd2;
    bus.alucont = 4'b1010; bus.start = 1'b1;
    nd = 0;
    for (int i = 1; i <= 110; i++) begin
      @(posedge clk);
      #3;
      if (bus.done) nd++;
      if (i == 75) begin
        @(negedge clk);
        bus.start = 1'b0;
      end
    end
    chk("b2b_ndone", nd, 3);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
